// File: rtl/spi_slave_egress_packer_pkg.sv
// Shared types and helpers for the SPI slave egress path (packer and serializer).
package spi_egress_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } egress_pack_state_t;

  // Byte sent by the serializer whenever the egress FIFO runs dry.
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h3C;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

  function automatic int len_w(input int dw);
    return $clog2(dw / 8 + 1);
  endfunction

endpackage

// File: rtl/spi_slave_egress_packer.sv
// Packs one wide readout word per frame into an 8-bit AXI-Stream: optional header byte,
// then the word's valid bytes, tlast on the final data byte.
module spi_slave_egress_packer
  import spi_egress_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter bit         MSB_FIRST  = 1'b1,
  parameter bit         HEADER_EN  = 1'b1,
  parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEFAULT,
  localparam int        NBYTES     = nbytes(DATA_WIDTH),
  localparam int        LW         = len_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LW-1:0]         s_axis_tlen,
  input  logic [7:0]            s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [7:0]            m_axis_tuser,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output egress_pack_state_t    dbg_state
);

  // Handshake rule on both sides: a transfer happens on a rising clk edge where
  // valid and ready are both 1; a raised valid holds its payload until that edge.

  egress_pack_state_t    state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic                  tvalid_q, tvalid_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [LW-1:0]         len_in;
  logic [LW-1:0]         idx_nxt;
  logic                  s_hs, m_hs;

  function automatic logic [7:0] sel_byte(input logic [DATA_WIDTH-1:0] w,
                                          input logic [LW-1:0] len,
                                          input logic [LW-1:0] idx);
    logic [LW-1:0] b;
    logic [7:0]    res;
    res = 8'h00;
    b   = MSB_FIRST ? (len - idx - LW'(1)) : idx;
    for (int i = 0; i < NBYTES; i++) begin
      if (b == LW'(i)) res = w[i*8 +: 8];
    end
    return res;
  endfunction

  // Zero or oversize lengths mean a full word.
  assign len_in = ((s_axis_tlen == '0) || (s_axis_tlen > LW'(NBYTES))) ? LW'(NBYTES)
                                                                       : s_axis_tlen;
  assign idx_nxt       = idx_q + LW'(1);
  assign s_axis_tready = (state_q == IDLE) && !rst;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = tvalid_q && m_axis_tready;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    len_d    = len_q;
    idx_d    = idx_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_hs) begin
          word_d   = s_axis_tdata;
          len_d    = len_in;
          idx_d    = '0;
          tvalid_d = 1'b1;
          if (HEADER_EN) begin
            state_d = HDR;
            tdata_d = s_axis_tuser;
            tlast_d = 1'b0;
          end else begin
            state_d = DATA;
            tdata_d = sel_byte(s_axis_tdata, len_in, '0);
            tlast_d = (len_in == LW'(1));
          end
        end
      end
      HDR: begin
        if (m_hs) begin
          state_d = DATA;
          tdata_d = sel_byte(word_q, len_q, '0);
          tlast_d = (len_q == LW'(1));
        end
      end
      DATA: begin
        if (m_hs) begin
          if (tlast_q) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 8'h00;
            cnt_d    = cnt_q + 16'd1;
          end else begin
            idx_d   = idx_nxt;
            tdata_d = sel_byte(word_q, len_q, idx_nxt);
            tlast_d = (idx_nxt == len_q - LW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = IDLE_BYTE;
  assign busy          = (state_q != IDLE);
  assign frame_count   = cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_slave_egress_packer.sv
// Bench for spi_slave_egress_packer: three configurations (MSB+header, LSB+header,
// MSB without header) checked against a byte-level scoreboard.
module tb_spi_slave_egress_packer;
  import spi_egress_pkg::*;

  localparam int DW = 64;
  localparam int LW = 4;
  localparam int ND = 3;
  localparam logic [63:0] W = 64'h0807060504030201;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]      s_tdata;
  logic [LW-1:0]      s_tlen;
  logic [7:0]         s_tuser;
  logic               s_tvalid [ND];
  logic               s_tready [ND];
  logic [7:0]         m_tdata  [ND];
  logic               m_tvalid [ND];
  logic               m_tready [ND];
  logic               m_tlast  [ND];
  logic [7:0]         m_tuser  [ND];
  logic               busy     [ND];
  logic [15:0]        fcnt     [ND];
  egress_pack_state_t st       [ND];

  spi_slave_egress_packer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .HEADER_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tlen(s_tlen),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]), .busy(busy[0]),
    .frame_count(fcnt[0]), .dbg_state(st[0]));

  spi_slave_egress_packer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0), .HEADER_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tlen(s_tlen),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]), .busy(busy[1]),
    .frame_count(fcnt[1]), .dbg_state(st[1]));

  spi_slave_egress_packer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .HEADER_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tlen(s_tlen),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
    .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]),
    .m_axis_tlast(m_tlast[2]), .m_axis_tuser(m_tuser[2]), .busy(busy[2]),
    .frame_count(fcnt[2]), .dbg_state(st[2]));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: {tlast, byte} per DUT
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];

  function automatic void push_exp(input int k, input logic [8:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [8:0] pop_exp(input int k);
    case (k)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  // Reference: DUT 1 is LSB-first, DUT 2 has no header.
  function automatic void push_frame(input int k, input logic [63:0] data,
                                     input logic [3:0] tlen, input logic [7:0] user);
    int n;
    int b;
    logic [7:0] by;
    n = ((tlen == 4'd0) || (tlen > 4'd8)) ? 8 : int'(tlen);
    if (k != 2) push_exp(k, {1'b0, user});
    for (int i = 0; i < n; i++) begin
      b  = (k != 1) ? (n - 1 - i) : i;
      by = data[b*8 +: 8];
      push_exp(k, {(i == n - 1), by});
    end
  endfunction

  // m_axis_tready driver: 0 always-ready, 1 toggle, 2 random, 3 stalled
  int bp_mode = 0;
  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      case (bp_mode)
        1:       m_tready[k] = (m_tready[k] !== 1'b1);
        2:       m_tready[k] = ($urandom_range(0, 3) != 0);
        3:       m_tready[k] = 1'b0;
        default: m_tready[k] = 1'b1;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         first_cyc  [ND];
  int         tlast_cyc  [ND];
  int         gap        [ND];
  bit         in_frame   [ND];
  bit         prev_stall [ND];
  logic [7:0] prev_data  [ND];
  logic       prev_last  [ND];

  // output monitor
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      check($sformatf("tuser%0d", k), m_tuser[k], 8'h3C);
      if (rst) begin
        prev_stall[k] = 1'b0;
        in_frame[k]   = 1'b0;
      end else begin
        if (prev_stall[k]) begin
          check($sformatf("stall_valid%0d", k), m_tvalid[k], 1'b1);
          check($sformatf("stall_data%0d", k), m_tdata[k], prev_data[k]);
          check($sformatf("stall_last%0d", k), m_tlast[k], prev_last[k]);
        end
        if (busy[k]) check($sformatf("s_tready_busy%0d", k), s_tready[k], 1'b0);
        if (m_tvalid[k] && m_tready[k]) begin
          if (q_size(k) == 0) check($sformatf("spurious_byte%0d", k), q_size(k), 1);
          else check($sformatf("byte%0d", k), {m_tlast[k], m_tdata[k]}, pop_exp(k));
          if (!in_frame[k]) begin
            first_cyc[k] = cyc;
            gap[k]       = cyc - tlast_cyc[k];
          end
          if (m_tlast[k]) begin
            tlast_cyc[k] = cyc;
            in_frame[k]  = 1'b0;
          end else begin
            in_frame[k] = 1'b1;
          end
        end
        prev_stall[k] = m_tvalid[k] && !m_tready[k];
        prev_data[k]  = m_tdata[k];
        prev_last[k]  = m_tlast[k];
      end
    end
  end

  // driver: call at a negedge; returns at the negedge after every selected DUT accepted
  task automatic send(input int mask, input logic [63:0] data, input logic [3:0] tlen,
                      input logic [7:0] user);
    bit acc [ND];
    bit any;
    int budget;
    budget  = 0;
    s_tdata = data;
    s_tlen  = tlen;
    s_tuser = user;
    for (int k = 0; k < ND; k++) begin
      if (mask[k]) begin
        push_frame(k, data, tlen, user);
        s_tvalid[k] = 1'b1;
      end
    end
    do begin
      for (int k = 0; k < ND; k++) acc[k] = s_tvalid[k] && s_tready[k];
      @(negedge clk);
      any = 1'b0;
      for (int k = 0; k < ND; k++) begin
        if (acc[k]) s_tvalid[k] = 1'b0;
        if (s_tvalid[k]) any = 1'b1;
      end
      budget++;
    end while (any && budget < 200);
    if (any) begin
      check("send_timeout", budget, 0);
      for (int k = 0; k < ND; k++) s_tvalid[k] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int mask);
    int  budget;
    bit  pending;
    budget = 0;
    do begin
      @(negedge clk);
      pending = 1'b0;
      for (int k = 0; k < ND; k++)
        if (mask[k] && (q_size(k) != 0 || busy[k])) pending = 1'b1;
      budget++;
    end while (pending && budget < 400);
    if (pending) check("drain_timeout", budget, 0);
  endtask

  initial begin
    logic [63:0] rd;
    logic [3:0]  rl;
    logic [7:0]  ru;
    for (int k = 0; k < ND; k++) begin
      s_tvalid[k]  = 1'b0;
      tlast_cyc[k] = 0;
      first_cyc[k] = 0;
      gap[k]       = 0;
    end
    s_tdata = '0;
    s_tlen  = '0;
    s_tuser = '0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("rst_s_tready%0d", k), s_tready[k], 1'b0);
      check($sformatf("rst_tvalid%0d", k), m_tvalid[k], 1'b0);
      check($sformatf("rst_tlast%0d", k), m_tlast[k], 1'b0);
      check($sformatf("rst_tdata%0d", k), m_tdata[k], 8'h00);
      check($sformatf("rst_busy%0d", k), busy[k], 1'b0);
      check($sformatf("rst_fcnt%0d", k), fcnt[k], 16'h0000);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) check($sformatf("post_rst_s_tready%0d", k), s_tready[k], 1'b1);
    @(negedge clk);

    // full word, MSB first with header, no backpressure
    send(1, W, 4'd0, 8'hA5);
    wait_drain(1);
    check("t1_nine_cycles", tlast_cyc[0] - first_cyc[0], 8);
    check("t1_fcnt", fcnt[0], 16'd1);

    // LSB first, short frame
    send(2, W, 4'd3, 8'hA5);
    wait_drain(2);
    check("t2_fcnt", fcnt[1], 16'd1);

    // toggling backpressure
    bp_mode = 1;
    send(1, W, 4'd0, 8'hA5);
    wait_drain(1);
    bp_mode = 0;
    check("t3_fcnt", fcnt[0], 16'd2);

    // no header, back-to-back words
    send(4, W, 4'd2, 8'h00);
    send(4, W, 4'd8, 8'h00);
    wait_drain(4);
    check("t4_bubble", gap[2], 2);
    check("t4_fcnt", fcnt[2], 16'd2);

    // random words and lengths on all configurations, random backpressure
    bp_mode = 2;
    for (int r = 0; r < 8; r++) begin
      rd = {$urandom(), $urandom()};
      rl = 4'($urandom_range(0, 15));
      ru = 8'($urandom_range(0, 255));
      send(7, rd, rl, ru);
    end
    wait_drain(7);
    bp_mode = 0;
    check("rand_fcnt0", fcnt[0], 16'd10);
    check("rand_fcnt1", fcnt[1], 16'd9);
    check("rand_fcnt2", fcnt[2], 16'd10);
    @(negedge clk);

    // reset after the third byte of a frame
    send(1, W, 4'd0, 8'h5A);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_bytes_left", q_size(0), 6);
    check("t5_tvalid", m_tvalid[0], 1'b0);
    check("t5_tlast", m_tlast[0], 1'b0);
    check("t5_busy", busy[0], 1'b0);
    check("t5_fcnt", fcnt[0], 16'd0);
    check("t5_s_tready", s_tready[0], 1'b1);
    exp_q0.delete();
    @(negedge clk);
    send(1, W, 4'd0, 8'hA5);
    wait_drain(1);
    check("t5_fresh_fcnt", fcnt[0], 16'd1);

    // frame counter wrap
    force u_dut2.cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_dut2.cnt_q;
    @(negedge clk);
    check("t6_preload", fcnt[2], 16'hFFFF);
    send(4, W, 4'd1, 8'h00);
    wait_drain(4);
    check("t6_wrap", fcnt[2], 16'h0000);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
